// File: rtl/softmax_norm.sv
// Buffers N_CLASS clamped exp() samples, then emits each divided by their sum in Q5.10.
// First result DATA_W+1 cycles after the last accept, then one every DATA_W+1 cycles; input stalls (in_ready=0) while dividing/emitting.
module softmax_norm #(
  parameter int N_CLASS = 4,
  parameter int DATA_W  = 16,
  parameter int FRAC    = 10
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic        [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic                     drop_err
);

  localparam int IDX_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam int SUM_W = DATA_W + $clog2(N_CLASS);
  localparam int IT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {S_COLLECT, S_DIV, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IT_W-1:0]   iter_q, iter_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [SUM_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              drop_err_q, drop_err_d;
  logic [DATA_W-1:0] smp_q [N_CLASS];
  logic [DATA_W-1:0] smp_d [N_CLASS];

  logic [DATA_W-1:0]      in_clamp;
  logic                   accept;
  logic                   frame_done;
  logic                   div_last;
  logic                   out_end;
  logic                   load;
  logic [IDX_W-1:0]       load_idx;
  logic [DATA_W+FRAC-1:0] dividend;
  logic [SUM_W:0]         rem_shift;
  logic                   rem_ge;
  logic [SUM_W-1:0]       rem_step;
  logic [DATA_W-1:0]      quo_step;

  assign accept     = in_valid & in_ready;
  assign frame_done = accept && (cnt_q == IDX_W'(N_CLASS - 1));
  assign div_last   = (state_q == S_DIV) && (iter_q == IT_W'(DATA_W - 1));
  assign out_end    = (state_q == S_OUT) && (idx_q == IDX_W'(N_CLASS - 1));
  assign in_clamp   = in_data[DATA_W-1] ? '0 : in_data;

  // The quotient is below 2^DATA_W, so the top FRAC dividend bits preload the
  // remainder and only the low DATA_W bits need an iteration each.
  always_comb begin
    load_idx  = (state_q == S_OUT) ? idx_q + 1'b1 : '0;
    dividend  = {smp_q[load_idx], {FRAC{1'b0}}};
    rem_shift = {rem_q, quo_q[DATA_W-1]};
    rem_ge    = (rem_shift >= {1'b0, sum_q});
    rem_step  = rem_ge ? SUM_W'(rem_shift - {1'b0, sum_q}) : rem_shift[SUM_W-1:0];
    quo_step  = {quo_q[DATA_W-2:0], rem_ge};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COLLECT: if (frame_done) state_d = S_DIV;
      S_DIV:     if (div_last)   state_d = S_OUT;
      S_OUT:     state_d = out_end ? S_COLLECT : S_DIV;
      default:   state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_COLLECT);
    out_valid = (state_q == S_OUT);
    out_last  = out_end;
    out_data  = out_data_q;
    drop_err  = drop_err_q;
  end

  always_comb begin
    smp_d      = smp_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    iter_d     = iter_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    out_data_d = out_data_q;
    drop_err_d = drop_err_q | (in_valid & ~in_ready);
    load       = 1'b0;

    if (accept) begin
      smp_d[cnt_q] = in_clamp;
      sum_d        = sum_q + SUM_W'(in_clamp);
      cnt_d        = frame_done ? '0 : cnt_q + 1'b1;
    end
    if (frame_done) begin
      idx_d  = '0;
      iter_d = '0;
      load   = 1'b1;
    end

    case (state_q)
      S_DIV: begin
        rem_d  = rem_step;
        quo_d  = quo_step;
        iter_d = iter_q + 1'b1;
        // A zero sum means every sample clamped to 0; report 0 rather than all-ones.
        if (div_last) out_data_d = (sum_q == '0) ? '0 : quo_step;
      end
      S_OUT: begin
        if (out_end) begin
          sum_d = '0;
          cnt_d = '0;
        end else begin
          idx_d  = idx_q + 1'b1;
          iter_d = '0;
          load   = 1'b1;
        end
      end
      default: ;
    endcase

    if (load) begin
      rem_d = SUM_W'(dividend[DATA_W+FRAC-1:DATA_W]);
      quo_d = dividend[DATA_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      iter_q     <= '0;
      sum_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      out_data_q <= '0;
      drop_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      iter_q     <= iter_d;
      sum_q      <= sum_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      out_data_q <= out_data_d;
      drop_err_q <= drop_err_d;
    end
  end

  always_ff @(posedge CLK) begin
    smp_q <= smp_d;
  end

endmodule
